// File: rtl/rv_multicycle_ctrl.sv
// rv_multicycle_ctrl
//   Multicycle control FSM for the RV64 datapath (PC, IR, register bank,
//   A/B registers, ULA operand muxes, MDR). Produces every load/write enable
//   and mux selector. Memory accesses use a req/ready handshake with a bounded
//   wait; illegal encodings trap, ECALL/EBREAK halt. Both end states are
//   absorbing until reset.
//
// Ports
//   clock, reset         rising-edge clock, synchronous active-high reset
//   opcode/funct3        IR[6:0] / IR[14:12]
//   funct7b5             IR[30] (selects SUB for R-type funct3=000)
//   ula_igual            ULA equality flag (A==B)
//   mem_ready            memory completed the current request this cycle
//   pc_write, ir_load, ab_load, mdr_load, reg_write   datapath enables
//   mem_req, mem_we      memory request / write strobe (mem_we valid with mem_req)
//   ula_a_sel            0=PC 1=A 2=old PC 3=zero
//   ula_b_sel            0=B 1=const 4 2=imm
//   ula_sel              0=ADD 1=SUB 2=AND 3=OR 4=XOR
//   wb_sel               0=ULA result 1=MDR 2=PC+4
//   halted, trap         sticky status (held by the absorbing end states)
//   state                current state encoding, for debug
module rv_multicycle_ctrl #(
  parameter int unsigned SEL_W       = 3,
  parameter int unsigned ULA_SEL_W   = 3,
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned CNT_W       = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [6:0]           opcode,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 ula_igual,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 ir_load,
  output logic                 ab_load,
  output logic                 mdr_load,
  output logic                 reg_write,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [SEL_W-1:0]     ula_a_sel,
  output logic [SEL_W-1:0]     ula_b_sel,
  output logic [ULA_SEL_W-1:0] ula_sel,
  output logic [1:0]           wb_sel,
  output logic                 halted,
  output logic                 trap,
  output logic [3:0]           state
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC_R = 4'd2,
    S_EXEC_I = 4'd3,
    S_WB     = 4'd4,
    S_ADDR   = 4'd5,
    S_MEM_RD = 4'd6,
    S_LD_WB  = 4'd7,
    S_MEM_WR = 4'd8,
    S_BRANCH = 4'd9,
    S_BR_TGT = 4'd10,
    S_JAL    = 4'd11,
    S_LUI    = 4'd12,
    S_HALT   = 4'd13,
    S_TRAP   = 4'd14
  } state_e;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [SEL_W-1:0] A_PC    = SEL_W'(0);
  localparam logic [SEL_W-1:0] A_REG   = SEL_W'(1);
  localparam logic [SEL_W-1:0] A_OLDPC = SEL_W'(2);
  localparam logic [SEL_W-1:0] A_ZERO  = SEL_W'(3);
  localparam logic [SEL_W-1:0] B_REG   = SEL_W'(0);
  localparam logic [SEL_W-1:0] B_FOUR  = SEL_W'(1);
  localparam logic [SEL_W-1:0] B_IMM   = SEL_W'(2);

  localparam logic [ULA_SEL_W-1:0] ULA_ADD = ULA_SEL_W'(0);
  localparam logic [ULA_SEL_W-1:0] ULA_SUB = ULA_SEL_W'(1);
  localparam logic [ULA_SEL_W-1:0] ULA_AND = ULA_SEL_W'(2);
  localparam logic [ULA_SEL_W-1:0] ULA_OR  = ULA_SEL_W'(3);
  localparam logic [ULA_SEL_W-1:0] ULA_XOR = ULA_SEL_W'(4);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MEM_TIMEOUT);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               wait_st;
  logic               timeout;
  logic               f3_ok;
  logic [ULA_SEL_W-1:0] f3_ula;

  // funct3 -> ULA function for R/I types; SUB only reachable from EXEC_R.
  always_comb begin
    f3_ok  = 1'b1;
    f3_ula = ULA_ADD;
    case (funct3)
      3'b000:  f3_ula = (state_q == S_EXEC_R && funct7b5) ? ULA_SUB : ULA_ADD;
      3'b111:  f3_ula = ULA_AND;
      3'b110:  f3_ula = ULA_OR;
      3'b100:  f3_ula = ULA_XOR;
      default: f3_ok  = 1'b0;
    endcase
  end

  // The counter holds the number of ready-low cycles already spent in the
  // current wait state; once it equals MEM_TIMEOUT another low cycle traps,
  // while a ready arriving in that same cycle is still accepted.
  assign wait_st = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
  assign timeout = wait_st && !mem_ready && (cnt_q == CNT_MAX);
  assign cnt_d   = (wait_st && !mem_ready && !timeout) ? cnt_q + CNT_W'(1) : '0;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (mem_ready)    state_d = S_DECODE;
        else if (timeout) state_d = S_TRAP;
      end
      S_DECODE: begin
        case (opcode)
          OP_R:                state_d = S_EXEC_R;
          OP_I:                state_d = S_EXEC_I;
          OP_LOAD, OP_STORE:   state_d = S_ADDR;
          OP_BRANCH:           state_d = S_BRANCH;
          OP_JAL:              state_d = S_JAL;
          OP_LUI:              state_d = S_LUI;
          OP_SYSTEM:           state_d = S_HALT;
          default:             state_d = S_TRAP;
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = f3_ok ? S_WB : S_TRAP;
      S_WB:               state_d = S_FETCH;
      S_ADDR:             state_d = (opcode == OP_LOAD) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD: begin
        if (mem_ready)    state_d = S_LD_WB;
        else if (timeout) state_d = S_TRAP;
      end
      S_LD_WB:            state_d = S_FETCH;
      S_MEM_WR: begin
        if (mem_ready)    state_d = S_FETCH;
        else if (timeout) state_d = S_TRAP;
      end
      S_BRANCH: begin
        case (funct3)
          3'b000:  state_d = ula_igual  ? S_BR_TGT : S_FETCH;
          3'b001:  state_d = !ula_igual ? S_BR_TGT : S_FETCH;
          default: state_d = S_TRAP;
        endcase
      end
      S_BR_TGT, S_JAL, S_LUI: state_d = S_FETCH;
      S_HALT:             state_d = S_HALT;
      S_TRAP:             state_d = S_TRAP;
      default:            state_d = S_TRAP;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are held at zero while reset is asserted, so FETCH's request does
  // not leak out during the reset cycle.
  always_comb begin
    pc_write  = 1'b0;
    ir_load   = 1'b0;
    ab_load   = 1'b0;
    mdr_load  = 1'b0;
    reg_write = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ula_a_sel = A_PC;
    ula_b_sel = B_REG;
    ula_sel   = ULA_ADD;
    wb_sel    = 2'd0;
    halted    = 1'b0;
    trap      = 1'b0;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          mem_req   = 1'b1;
          ir_load   = mem_ready;
          pc_write  = mem_ready;
          ula_a_sel = A_PC;
          ula_b_sel = B_FOUR;
        end
        S_DECODE: ab_load = 1'b1;
        S_EXEC_R: begin
          ula_a_sel = A_REG;
          ula_b_sel = B_REG;
          ula_sel   = f3_ula;
        end
        S_EXEC_I: begin
          ula_a_sel = A_REG;
          ula_b_sel = B_IMM;
          ula_sel   = f3_ula;
        end
        S_WB: reg_write = 1'b1;
        S_ADDR: begin
          ula_a_sel = A_REG;
          ula_b_sel = B_IMM;
        end
        S_MEM_RD: begin
          mem_req  = 1'b1;
          mdr_load = mem_ready;
        end
        S_LD_WB: begin
          reg_write = 1'b1;
          wb_sel    = 2'd1;
        end
        S_MEM_WR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
        end
        S_BRANCH: begin
          ula_a_sel = A_REG;
          ula_b_sel = B_REG;
          ula_sel   = ULA_SUB;
        end
        S_BR_TGT: begin
          pc_write  = 1'b1;
          ula_a_sel = A_OLDPC;
          ula_b_sel = B_IMM;
        end
        S_JAL: begin
          reg_write = 1'b1;
          wb_sel    = 2'd2;
          pc_write  = 1'b1;
          ula_a_sel = A_OLDPC;
          ula_b_sel = B_IMM;
        end
        // LUI result is 0 + imm through the ULA.
        S_LUI: begin
          reg_write = 1'b1;
          ula_a_sel = A_ZERO;
          ula_b_sel = B_IMM;
        end
        S_HALT: halted = 1'b1;
        S_TRAP: trap   = 1'b1;
        default: ;
      endcase
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_rv_multicycle_ctrl.sv
// tb_rv_multicycle_ctrl
//   Directed bench for rv_multicycle_ctrl: walks each instruction class cycle
//   by cycle and compares state, enables and selectors against hand-derived
//   values, including wait-counter boundaries and mid-operation reset.
module tb_rv_multicycle_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       ula_igual;
  logic       mem_ready;
  logic       pc_write, ir_load, ab_load, mdr_load, reg_write;
  logic       mem_req, mem_we, halted, trap;
  logic [2:0] ula_a_sel, ula_b_sel, ula_sel;
  logic [1:0] wb_sel;
  logic [3:0] state;

  int unsigned n_chk = 0;
  int unsigned n_bad = 0;
  int unsigned mdr_cnt;

  // Enable vector: {pc_write, ir_load, ab_load, mdr_load, reg_write,
  //                 mem_req, mem_we, halted, trap}
  localparam logic [8:0] E_NONE   = 9'b000000000;
  localparam logic [8:0] E_FETCH  = 9'b110001000;
  localparam logic [8:0] E_REQ    = 9'b000001000;
  localparam logic [8:0] E_AB     = 9'b001000000;
  localparam logic [8:0] E_WB     = 9'b000010000;
  localparam logic [8:0] E_RDDONE = 9'b000101000;
  localparam logic [8:0] E_WR     = 9'b000001100;
  localparam logic [8:0] E_PC     = 9'b100000000;
  localparam logic [8:0] E_JAL    = 9'b100010000;
  localparam logic [8:0] E_HALT   = 9'b000000010;
  localparam logic [8:0] E_TRAP   = 9'b000000001;

  rv_multicycle_ctrl #(
    .SEL_W       (3),
    .ULA_SEL_W   (3),
    .MEM_TIMEOUT (15),
    .CNT_W       (4)
  ) dut (
    .clock     (clock),
    .reset     (reset),
    .opcode    (opcode),
    .funct3    (funct3),
    .funct7b5  (funct7b5),
    .ula_igual (ula_igual),
    .mem_ready (mem_ready),
    .pc_write  (pc_write),
    .ir_load   (ir_load),
    .ab_load   (ab_load),
    .mdr_load  (mdr_load),
    .reg_write (reg_write),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .ula_a_sel (ula_a_sel),
    .ula_b_sel (ula_b_sel),
    .ula_sel   (ula_sel),
    .wb_sel    (wb_sel),
    .halted    (halted),
    .trap      (trap),
    .state     (state)
  );

  always #5 clock = ~clock;

  function automatic logic [10:0] sl(logic [2:0] a, logic [2:0] b, logic [2:0] u, logic [1:0] w);
    return {a, b, u, w};
  endfunction

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic expect_cyc(string tag, logic [3:0] st, logic [8:0] en, logic [10:0] sel);
    #1;
    chk({tag, "_st"}, 32'(state), 32'(st));
    chk({tag, "_en"}, 32'({pc_write, ir_load, ab_load, mdr_load, reg_write,
                           mem_req, mem_we, halted, trap}), 32'(en));
    chk({tag, "_sel"}, 32'({ula_a_sel, ula_b_sel, ula_sel, wb_sel}), 32'(sel));
  endtask

  // Starts in FETCH with zero-wait memory; returns with the FSM one state past DECODE.
  task automatic fetch_decode(string tag, logic [6:0] op, logic [2:0] f3, logic f7);
    opcode    = op;
    funct3    = f3;
    funct7b5  = f7;
    mem_ready = 1'b1;
    expect_cyc({tag, "_fetch"}, 4'd0, E_FETCH, sl(0, 1, 0, 0));
    tick();
    expect_cyc({tag, "_dec"}, 4'd1, E_AB, sl(0, 0, 0, 0));
    tick();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic rtype(string tag, logic [2:0] f3, logic f7, logic [2:0] u);
    fetch_decode(tag, 7'b0110011, f3, f7);
    expect_cyc({tag, "_ex"}, 4'd2, E_NONE, sl(1, 0, u, 0));
    tick();
    expect_cyc({tag, "_wb"}, 4'd4, E_WB, sl(0, 0, 0, 0));
    tick();
  endtask

  initial begin
    reset = 1'b1; opcode = '0; funct3 = '0; funct7b5 = 1'b0;
    ula_igual = 1'b0; mem_ready = 1'b1;
    tick();
    expect_cyc("reset", 4'd0, E_NONE, sl(0, 0, 0, 0));
    tick();
    reset = 1'b0;

    rtype("add", 3'b000, 1'b0, 3'd0);
    rtype("sub", 3'b000, 1'b1, 3'd1);
    rtype("or",  3'b110, 1'b0, 3'd3);
    rtype("xor", 3'b100, 1'b0, 3'd4);

    // load with three ready-low cycles in MEM_RD
    fetch_decode("ld", 7'b0000011, 3'b011, 1'b0);
    expect_cyc("ld_addr", 4'd5, E_NONE, sl(1, 2, 0, 0));
    tick();
    mem_ready = 1'b0;
    mdr_cnt = 0;
    for (int i = 0; i < 3; i++) begin
      expect_cyc("ld_wait", 4'd6, E_REQ, sl(0, 0, 0, 0));
      mdr_cnt += 32'(mdr_load);
      tick();
    end
    mem_ready = 1'b1;
    expect_cyc("ld_done", 4'd6, E_RDDONE, sl(0, 0, 0, 0));
    mdr_cnt += 32'(mdr_load);
    tick();
    expect_cyc("ld_wb", 4'd7, E_WB, sl(0, 0, 0, 1));
    mdr_cnt += 32'(mdr_load);
    chk("mdr_once", mdr_cnt, 1);
    tick();

    // branches
    ula_igual = 1'b1;
    fetch_decode("beq", 7'b1100011, 3'b000, 1'b0);
    expect_cyc("beq_br", 4'd9, E_NONE, sl(1, 0, 1, 0));
    tick();
    expect_cyc("beq_tgt", 4'd10, E_PC, sl(2, 2, 0, 0));
    tick();
    fetch_decode("bne", 7'b1100011, 3'b001, 1'b0);
    expect_cyc("bne_br", 4'd9, E_NONE, sl(1, 0, 1, 0));
    tick();

    fetch_decode("jal", 7'b1101111, 3'b000, 1'b0);
    expect_cyc("jal", 4'd11, E_JAL, sl(2, 2, 0, 2));
    tick();
    fetch_decode("lui", 7'b0110111, 3'b000, 1'b0);
    expect_cyc("lui", 4'd12, E_WB, sl(3, 2, 0, 0));
    tick();

    fetch_decode("sd", 7'b0100011, 3'b011, 1'b0);
    expect_cyc("sd_addr", 4'd5, E_NONE, sl(1, 2, 0, 0));
    tick();
    expect_cyc("sd_wr", 4'd8, E_WR, sl(0, 0, 0, 0));
    tick();

    // I-type ignores funct7b5: never SUB
    fetch_decode("addi", 7'b0010011, 3'b000, 1'b1);
    expect_cyc("addi_ex", 4'd3, E_NONE, sl(1, 2, 0, 0));
    tick();
    expect_cyc("addi_wb", 4'd4, E_WB, sl(0, 0, 0, 0));
    tick();
    fetch_decode("andi", 7'b0010011, 3'b111, 1'b0);
    expect_cyc("andi_ex", 4'd3, E_NONE, sl(1, 2, 2, 0));
    tick();
    tick();

    // illegal R funct3 traps after EXEC_R and stays trapped
    fetch_decode("rbad", 7'b0110011, 3'b001, 1'b0);
    expect_cyc("rbad_ex", 4'd2, E_NONE, sl(1, 0, 0, 0));
    tick();
    expect_cyc("rbad_trap", 4'd14, E_TRAP, sl(0, 0, 0, 0));
    tick();
    expect_cyc("rbad_stick", 4'd14, E_TRAP, sl(0, 0, 0, 0));
    do_reset();

    fetch_decode("bbad", 7'b1100011, 3'b010, 1'b0);
    expect_cyc("bbad_br", 4'd9, E_NONE, sl(1, 0, 1, 0));
    tick();
    expect_cyc("bbad_trap", 4'd14, E_TRAP, sl(0, 0, 0, 0));
    do_reset();

    fetch_decode("ill", 7'b1111111, 3'b000, 1'b0);
    expect_cyc("ill_trap", 4'd14, E_TRAP, sl(0, 0, 0, 0));
    tick();
    mem_ready = 1'b0;
    expect_cyc("ill_stick", 4'd14, E_TRAP, sl(0, 0, 0, 0));
    do_reset();

    fetch_decode("ecall", 7'b1110011, 3'b000, 1'b0);
    for (int i = 0; i < 3; i++) begin
      mem_ready = i[0];
      expect_cyc("halt", 4'd13, E_HALT, sl(0, 0, 0, 0));
      tick();
    end
    do_reset();

    // timeout: 15 ready-low cycles tolerated, the 16th traps
    mem_ready = 1'b0;
    repeat (15) tick();
    expect_cyc("tmo_edge", 4'd0, E_REQ, sl(0, 1, 0, 0));
    tick();
    expect_cyc("tmo_trap", 4'd14, E_TRAP, sl(0, 0, 0, 0));
    do_reset();

    // ready arriving when the count sits at the limit still wins
    opcode = 7'b0100011;
    funct3 = 3'b011;
    mem_ready = 1'b0;
    repeat (15) tick();
    mem_ready = 1'b1;
    expect_cyc("late_rdy", 4'd0, E_FETCH, sl(0, 1, 0, 0));
    tick();
    expect_cyc("late_dec", 4'd1, E_AB, sl(0, 0, 0, 0));
    tick();
    tick();

    // reset in the middle of a stalled store
    mem_ready = 1'b0;
    repeat (5) begin
      expect_cyc("mw_wait", 4'd8, E_WR, sl(0, 0, 0, 0));
      tick();
    end
    reset = 1'b1;
    tick();
    expect_cyc("mw_rst", 4'd0, E_NONE, sl(0, 0, 0, 0));
    reset = 1'b0;
    expect_cyc("mw_fetch", 4'd0, E_REQ, sl(0, 1, 0, 0));
    repeat (15) tick();
    expect_cyc("mw_cnt0", 4'd0, E_REQ, sl(0, 1, 0, 0));
    tick();
    expect_cyc("mw_tmo", 4'd14, E_TRAP, sl(0, 0, 0, 0));

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
